ram8_arbiter: RTL and testbench
===============================

# ram8_arbiter

Two-port access controller for the 8-word × 16-bit RAM8 storage block. It accepts read/write commands from two independent requesters (A and B) and arbitrates between them. Each winning command is sequenced into a single RAM8 access, and completion is returned with a one-cycle done pulse plus captured read data. It sits between the RAM8 instance and its clients; the clients never drive RAM8 directly.

## Interface
- DATA_W, 16, word width; must match RAM8.
- ADDR_W, 3, client word-address width (8 words).
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_req  in  1  requester A command valid; held until a_done.
- a_we  in  1  A: 1 = write, 0 = read.
- a_addr  in  ADDR_W  A word address.
- a_wdata  in  DATA_W  A write data.
- a_done  out  1  one-cycle completion pulse to A.
- a_rdata  out  DATA_W  A read result; valid from a_done onward.
- b_req, b_we, b_addr, b_wdata, b_done, b_rdata: identical set for requester B.
- ram_inp  out  DATA_W  to RAM8 inp.
- ram_load  out  1  to RAM8 load.
- ram_addr  out  4  to RAM8 addr; bit 3 is always 0.
- ram_out  in  DATA_W  from RAM8 out; combinational read of the addressed word.
- busy  out  1  high while in ACCESS or RESP.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is high at a rising edge, select a winner, latch its we/addr/wdata and port id, and go to ACCESS. With no req, stay in IDLE.
- ACCESS: drive ram_addr = {0, latched addr} and ram_inp = latched wdata. Drive ram_load = latched we. At the closing edge:
  - a write commits in RAM8;
  - for a read, ram_out is captured into the winner's rdata register.
  - Then go to RESP.
- RESP: assert the winner's done for exactly this cycle, then return to IDLE. The loser's req is considered again in IDLE.
- Arbitration (RAM8_ARB_RR_EN defined): 2-way round-robin. After a grant to A, B has priority on the next arbitration, and vice versa. The pointer updates only on a grant.
- Requester rules:
  - Command fields are sampled once, at the grant edge. Later changes are ignored.
  - Dropping req after the grant does not cancel the access; done still pulses.
  - A requester that keeps req high after its done issues a new command.
- A write never alters either rdata. The non-winning port's rdata is unchanged.
- Outputs are registered. ram_load is high only in ACCESS.

## Timing
- Reset values: state IDLE, rr pointer favours A, a_done = b_done = 0, a_rdata = b_rdata = 0, ram_load = 0, ram_addr = 0, ram_inp = 0, busy = 0.
- Latency: req sampled at edge N (grant), ACCESS in cycle N+1, done high in cycle N+2, IDLE at N+3. Each access occupies 3 cycles, so peak throughput is 1 access per 3 cycles.
- Simultaneous A and B requests: one wins per the arbitration rule. The other is granted at the next IDLE edge, so its done follows the first done by 3 cycles.
- Asserting rst_n low mid-ACCESS asynchronously forces ram_load = 0 and all outputs to their reset values. The pending command is dropped with no done. A write whose edge coincides with reset assertion is not guaranteed to commit.
- Back-to-back requests from the same port are fair to B: with both held high, grants alternate A, B, A, B.

## Configuration
- RAM8_ARB_RR_EN defined: round-robin as above.
- RAM8_ARB_RR_EN undefined: fixed priority, A always beats B. The pointer logic is removed. B can starve while A holds req.

## Structure
- Package ram8_arb_pkg holds:
  - DATA_W, ADDR_W, RAM_ADDR_W = 4;
  - state enum {IDLE, ACCESS, RESP};
  - port-id encoding PORT_A = 0, PORT_B = 1.
- One sub-module, ram8_arb_pick: 2-way picker. It takes req pair, pointer, and grant-enable, and returns the winner id and the next pointer. Its RR/fixed behaviour is selected by RAM8_ARB_RR_EN.

## Test plan
- Reset: assert rst_n = 0 mid-run → all outputs 0, busy 0, state IDLE immediately, without waiting for a clk edge.
- Single write then read: A writes 0xBEEF to addr 5; a_done pulses 2 cycles after grant. A then reads addr 5 → a_rdata = 0xBEEF at a_done, and ram_addr = 4'b0101 during ACCESS.
- Contention (RR_EN defined): A and B both request in the same cycle, A writing 0x1111 to addr 0 and B reading addr 0. A is granted first; b_rdata = 0x1111 three cycles after a_done.
- Fairness: both reqs held high for 12 accesses → grant order A, B, A, B…; without RR_EN, 12 A grants and no b_done.
- Req withdrawn: B drops b_req the cycle after grant with we = 1, data 0x00FF, addr 7 → b_done still pulses; a later read of addr 7 returns 0x00FF.
- Reset during ACCESS of a write to addr 2 (prior value 0x0000), with reset not coincident with the edge → no done pulse, ram_load low immediately; a subsequent read of addr 2 returns 0x0000.

Source files
------------

// File: rtl/ram8_arbiter_pkg.sv
// Shared types and sizes for the RAM8 two-port access controller.
// Optional feature macro: RAM8_ARB_RR_EN (round-robin arbitration).
package ram8_arb_pkg;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 3;
  localparam int RAM_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/ram8_arbiter_if.sv
// Bus bundle between the two requesters, the controller and the RAM8 block.
// Optional feature macro: RAM8_ARB_RR_EN (affects the controller only).
interface ram8_arbiter_if;
  import ram8_arb_pkg::*;

  logic                  a_req;
  logic                  a_we;
  logic [ADDR_W-1:0]     a_addr;
  logic [DATA_W-1:0]     a_wdata;
  logic                  a_done;
  logic [DATA_W-1:0]     a_rdata;

  logic                  b_req;
  logic                  b_we;
  logic [ADDR_W-1:0]     b_addr;
  logic [DATA_W-1:0]     b_wdata;
  logic                  b_done;
  logic [DATA_W-1:0]     b_rdata;

  logic [DATA_W-1:0]     ram_inp;
  logic                  ram_load;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0]     ram_out;

  logic                  busy;

  // Controller side
  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  ram_out,
    output a_done, a_rdata, b_done, b_rdata,
    output ram_inp, ram_load, ram_addr, busy
  );

  // Requester / RAM side
  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output ram_out,
    input  a_done, a_rdata, b_done, b_rdata,
    input  ram_inp, ram_load, ram_addr, busy
  );

endinterface

// File: rtl/ram8_arbiter_pick.sv
// Two-way winner selection for the RAM8 controller.
// Optional feature macro: RAM8_ARB_RR_EN selects round-robin; otherwise A has
// fixed priority and there is no pointer.
module ram8_arb_pick
  import ram8_arb_pkg::*;
(
  input  logic  i_req_a,
  input  logic  i_req_b,
`ifdef RAM8_ARB_RR_EN
  input  port_e i_ptr,
  output port_e o_ptr_next,
`endif
  input  logic  i_grant_en,
  output logic  o_gnt,
  output port_e o_win
);

  assign o_gnt = i_grant_en & (i_req_a | i_req_b);

`ifdef RAM8_ARB_RR_EN
  // Pointer names the port that wins a tie; lone requesters always win
  always_comb begin
    o_win = i_req_b ? PORT_B : PORT_A;
    if (i_req_a && i_req_b) o_win = i_ptr;
  end

  // The port just served yields priority to the other one
  assign o_ptr_next = o_gnt ? ((o_win == PORT_A) ? PORT_B : PORT_A) : i_ptr;
`else
  assign o_win = i_req_a ? PORT_A : PORT_B;
`endif

endmodule

// File: rtl/ram8_arbiter.sv
// Two-port access controller for the 8x16 RAM8 block: arbitrates A/B commands,
// sequences one RAM access per grant, returns a done pulse and read data.
// Optional feature macro: RAM8_ARB_RR_EN (round-robin instead of A-priority).
module ram8_arbiter
  import ram8_arb_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  ram8_arbiter_if.slave  bus
);

  state_e                r_state;
  state_e                w_state_nxt;
  port_e                 r_port;
  logic                  r_we;
  logic                  w_gnt;
  port_e                 w_win;

  logic                  r_a_done;
  logic                  r_b_done;
  logic [DATA_W-1:0]     r_a_rdata;
  logic [DATA_W-1:0]     r_b_rdata;
  logic [DATA_W-1:0]     r_ram_inp;
  logic                  r_ram_load;
  logic [RAM_ADDR_W-1:0] r_ram_addr;
  logic                  r_busy;

  logic                  w_sel_we;
  logic [ADDR_W-1:0]     w_sel_addr;
  logic [DATA_W-1:0]     w_sel_wdata;

`ifdef RAM8_ARB_RR_EN
  port_e                 r_ptr;
  port_e                 w_ptr_next;

  ram8_arb_pick u_pick (
    .i_req_a    (bus.a_req),
    .i_req_b    (bus.b_req),
    .i_ptr      (r_ptr),
    .o_ptr_next (w_ptr_next),
    .i_grant_en (r_state == IDLE),
    .o_gnt      (w_gnt),
    .o_win      (w_win)
  );

  // Round-robin pointer; only moves on an actual grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ptr <= PORT_A;
    else        r_ptr <= w_ptr_next;
  end
`else
  ram8_arb_pick u_pick (
    .i_req_a    (bus.a_req),
    .i_req_b    (bus.b_req),
    .i_grant_en (r_state == IDLE),
    .o_gnt      (w_gnt),
    .o_win      (w_win)
  );
`endif

  assign w_sel_we    = (w_win == PORT_A) ? bus.a_we    : bus.b_we;
  assign w_sel_addr  = (w_win == PORT_A) ? bus.a_addr  : bus.b_addr;
  assign w_sel_wdata = (w_win == PORT_A) ? bus.a_wdata : bus.b_wdata;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: every grant walks IDLE -> ACCESS -> RESP -> IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_gnt) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered outputs: command latched at grant, result captured at end of ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_port     <= PORT_A;
      r_we       <= 1'b0;
      r_a_done   <= 1'b0;
      r_b_done   <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
      r_ram_inp  <= '0;
      r_ram_load <= 1'b0;
      r_ram_addr <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt) begin
            r_port     <= w_win;
            r_we       <= w_sel_we;
            r_ram_addr <= {1'b0, w_sel_addr};
            r_ram_inp  <= w_sel_wdata;
            r_ram_load <= w_sel_we;
            r_busy     <= 1'b1;
          end
        end
        ACCESS: begin
          r_ram_load <= 1'b0;
          if (!r_we) begin
            if (r_port == PORT_A) r_a_rdata <= bus.ram_out;
            else                  r_b_rdata <= bus.ram_out;
          end
          r_a_done <= (r_port == PORT_A);
          r_b_done <= (r_port == PORT_B);
        end
        RESP:    r_busy <= 1'b0;
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign bus.a_done   = r_a_done;
  assign bus.b_done   = r_b_done;
  assign bus.a_rdata  = r_a_rdata;
  assign bus.b_rdata  = r_b_rdata;
  assign bus.ram_inp  = r_ram_inp;
  assign bus.ram_load = r_ram_load;
  assign bus.ram_addr = r_ram_addr;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_ram8_arbiter.sv
// Directed bench for ram8_arbiter with a behavioural RAM8 attached.
// Builds with or without RAM8_ARB_RR_EN; arbitration expectations follow it.
module tb_ram8_arbiter;
  import ram8_arb_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [DATA_W-1:0] mem [8] = '{default: '0};

  ram8_arbiter_if bus ();

  ram8_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM8 model: synchronous write, combinational read, addr bit 3 ignored
  always @(posedge clk) if (bus.ram_load) mem[bus.ram_addr[2:0]] <= bus.ram_inp;
  assign bus.ram_out = mem[bus.ram_addr[2:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;

    // Power-on reset values
    #3;
    chk("rst_busy",    32'(bus.busy),     0);
    chk("rst_load",    32'(bus.ram_load), 0);
    chk("rst_addr",    32'(bus.ram_addr), 0);
    chk("rst_inp",     32'(bus.ram_inp),  0);
    chk("rst_a_done",  32'(bus.a_done),   0);
    chk("rst_b_done",  32'(bus.b_done),   0);
    chk("rst_a_rdata", 32'(bus.a_rdata),  0);
    chk("rst_b_rdata", 32'(bus.b_rdata),  0);
    tick();
    rst_n = 1'b1;
    tick();

    // A writes 0xBEEF to addr 5
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 3'd5; bus.a_wdata = 16'hBEEF;
    tick();
    chk("wr_acc_busy", 32'(bus.busy),     1);
    chk("wr_acc_load", 32'(bus.ram_load), 1);
    chk("wr_acc_addr", 32'(bus.ram_addr), 32'h5);
    chk("wr_acc_inp",  32'(bus.ram_inp),  32'hBEEF);
    chk("wr_acc_done", 32'(bus.a_done),   0);
    tick();
    chk("wr_resp_a_done", 32'(bus.a_done),   1);
    chk("wr_resp_b_done", 32'(bus.b_done),   0);
    chk("wr_resp_load",   32'(bus.ram_load), 0);
    chk("wr_resp_busy",   32'(bus.busy),     1);
    chk("wr_a_rdata",     32'(bus.a_rdata),  0);
    bus.a_req = 0;
    tick();
    chk("wr_idle_done", 32'(bus.a_done), 0);
    chk("wr_idle_busy", 32'(bus.busy),   0);

    // A reads addr 5
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 3'd5;
    tick();
    chk("rd_acc_addr", 32'(bus.ram_addr), 32'h5);
    chk("rd_acc_load", 32'(bus.ram_load), 0);
    tick();
    chk("rd_a_done",  32'(bus.a_done),  1);
    chk("rd_a_rdata", 32'(bus.a_rdata), 32'hBEEF);
    chk("rd_b_rdata", 32'(bus.b_rdata), 0);
    bus.a_req = 0;
    tick();

    // B writes 0x00FF to addr 7, drops req and scrambles fields after grant
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 3'd7; bus.b_wdata = 16'h00FF;
    tick();
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = 3'd3; bus.b_wdata = 16'h1234;
    #1;
    chk("wd_acc_inp",  32'(bus.ram_inp),  32'h00FF);
    chk("wd_acc_addr", 32'(bus.ram_addr), 32'h7);
    chk("wd_acc_load", 32'(bus.ram_load), 1);
    tick();
    chk("wd_b_done", 32'(bus.b_done), 1);
    chk("wd_a_done", 32'(bus.a_done), 0);
    tick();
    chk("wd_idle_busy", 32'(bus.busy), 0);

    // B reads addr 7
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 3'd7;
    tick();
    tick();
    chk("rd7_b_done",  32'(bus.b_done),  1);
    chk("rd7_b_rdata", 32'(bus.b_rdata), 32'h00FF);
    chk("rd7_a_rdata", 32'(bus.a_rdata), 32'hBEEF);
    bus.b_req = 0;
    tick();

    // Contention: A writes 0x1111 to addr 0, B reads addr 0; A goes first
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 3'd0; bus.a_wdata = 16'h1111;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 3'd0;
    tick();
    chk("ct_acc_load", 32'(bus.ram_load), 1);
    chk("ct_acc_inp",  32'(bus.ram_inp),  32'h1111);
    tick();
    chk("ct_a_done1", 32'(bus.a_done), 1);
    chk("ct_b_done1", 32'(bus.b_done), 0);
    bus.a_req = 0;
    tick();
    chk("ct_gap_busy", 32'(bus.busy), 0);
    tick();
    chk("ct_b_acc_busy", 32'(bus.busy),     1);
    chk("ct_b_acc_load", 32'(bus.ram_load), 0);
    tick();
    chk("ct_b_done2",  32'(bus.b_done),  1);
    chk("ct_a_done2",  32'(bus.a_done),  0);
    chk("ct_b_rdata",  32'(bus.b_rdata), 32'h1111);
    chk("ct_a_rdata",  32'(bus.a_rdata), 32'hBEEF);
    bus.b_req = 0;
    tick();

    // Fairness: both held for 12 accesses
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 3'd5;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 3'd7;
    for (int i = 0; i < 12; i++) begin
      tick();
      tick();
`ifdef RAM8_ARB_RR_EN
      chk($sformatf("fair_a_done_%0d", i), 32'(bus.a_done), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("fair_b_done_%0d", i), 32'(bus.b_done), (i % 2 == 0) ? 0 : 1);
`else
      chk($sformatf("fair_a_done_%0d", i), 32'(bus.a_done), 1);
      chk($sformatf("fair_b_done_%0d", i), 32'(bus.b_done), 0);
`endif
      tick();
    end
    bus.a_req = 0; bus.b_req = 0;
    chk("fair_a_rdata", 32'(bus.a_rdata), 32'hBEEF);
    tick();

    // Reset asserted mid-ACCESS of A write 0xDEAD to addr 2
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 3'd2; bus.a_wdata = 16'hDEAD;
    tick();
    chk("ra_pre_load", 32'(bus.ram_load), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ra_load",    32'(bus.ram_load), 0);
    chk("ra_busy",    32'(bus.busy),     0);
    chk("ra_addr",    32'(bus.ram_addr), 0);
    chk("ra_inp",     32'(bus.ram_inp),  0);
    chk("ra_a_rdata", 32'(bus.a_rdata),  0);
    chk("ra_b_rdata", 32'(bus.b_rdata),  0);
    bus.a_req = 0;
    tick();
    chk("ra_a_done", 32'(bus.a_done), 0);
    rst_n = 1'b1;
    tick();
    chk("ra_post_a_done", 32'(bus.a_done), 0);

    // Read addr 2 back: write must not have committed
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 3'd2;
    tick();
    chk("ra_rd_addr", 32'(bus.ram_addr), 32'h2);
    tick();
    chk("ra_rd_done",  32'(bus.a_done),  1);
    chk("ra_rd_rdata", 32'(bus.a_rdata), 32'h0000);
    bus.a_req = 0;
    tick();

    // Addr 0 still holds the contention write
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 3'd0;
    tick();
    tick();
    chk("end_b_done",  32'(bus.b_done),  1);
    chk("end_b_rdata", 32'(bus.b_rdata), 32'h1111);
    bus.b_req = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
